// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline stall/flush controller.
// Enables and flushes are decoded combinationally from the registered FSM state
// and the current hazard/memory inputs. A wait counter tracks consecutive
// memory-wait cycles and raises a sticky mem_timeout.
// Optional feature macro: PIPE_PERF_COUNTERS_EN adds saturating stall/flush
// performance counters; without it both counter outputs are tied to zero.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_use_hazard,
    input  logic        branch_taken_EX,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        en_IF,
    output logic        en_ID,
    output logic        en_EX,
    output logic        en_MEM,
    output logic        en_WB,
    output logic        flush_ID,
    output logic        flush_EX,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2,
        StFlush     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic en_front;  // IF and ID enables
    logic en_back;   // EX, MEM and WB enables
    logic flush_id;
    logic flush_ex;

    // Decode enables, flushes and next state from current state and inputs.
    always_comb begin
        en_front = 1'b1;
        en_back  = 1'b1;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        state_d  = state_q;

        unique case (state_q)
            StRun, StMemWait: begin
                // Memory not finished: freeze the whole pipe, no bubbles.
                if ((state_q == StMemWait || mem_req) && !mem_ready) begin
                    en_front = 1'b0;
                    en_back  = 1'b0;
                    state_d  = StMemWait;
                end else if (branch_taken_EX) begin
                    // Branch wins over load-use: the stalled instruction is wrong-path.
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    state_d  = StFlush;
                end else if (load_use_hazard) begin
                    en_front = 1'b0;
                    flush_ex = 1'b1;
                    state_d  = StLoadStall;
                end else begin
                    state_d  = StRun;
                end
            end
            StLoadStall: begin
                state_d = StRun;
            end
            StFlush: begin
                flush_id = 1'b1;
                state_d  = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (reset) begin
            en_front = 1'b0;
            en_back  = 1'b0;
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = StRun;
        end
    end

    assign en_IF    = en_front;
    assign en_ID    = en_front;
    assign en_EX    = en_back;
    assign en_MEM   = en_back;
    assign en_WB    = en_back;
    assign flush_ID = flush_id;
    assign flush_EX = flush_ex;
    assign state    = state_q;

    // Wait counter: cleared on entry to MEM_WAIT, counts waiting cycles, saturates.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (state_q != StMemWait && state_d == StMemWait) begin
            wait_cnt_d = '0;
        end else if (state_q == StMemWait && !mem_ready && wait_cnt_q < MEM_TIMEOUT) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
        if (state_q == StMemWait && wait_cnt_d >= MEM_TIMEOUT) begin
            mem_timeout_d = 1'b1;
        end
    end

    // FSM state, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Reset must win even in the first reset cycle, before the flop clears.
    assign mem_timeout = mem_timeout_q & ~reset;

`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; a branch redirect is the only case with flush_EX and en_IF both set.
    always_comb begin
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        if (!en_front && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
        if (flush_ex && en_front && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_q     <= stall_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = reset ? 32'd0 : stall_q;
    assign flush_count  = reset ? 32'd0 : flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl (MEM_TIMEOUT=8). Expected output vectors are pushed
// to a scoreboard queue as each cycle's stimulus is driven and popped at the
// following negedge for comparison.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_use_hazard;
    logic        branch_taken_EX;
    logic        mem_req;
    logic        mem_ready;
    logic        en_IF, en_ID, en_EX, en_MEM, en_WB;
    logic        flush_ID, flush_EX;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];

    // {en_IF,en_ID,en_EX,en_MEM,en_WB,flush_ID,flush_EX}
    localparam logic [6:0] ALL1 = 7'b11111_00;
    localparam logic [6:0] LDST = 7'b00111_01;
    localparam logic [6:0] BLK  = 7'b00000_00;
    localparam logic [6:0] BRF  = 7'b11111_11;
    localparam logic [6:0] FLS  = 7'b11111_10;
    localparam logic [6:0] RST  = 7'b00000_11;

    pipe_ctrl #(.MEM_TIMEOUT(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_use_hazard (load_use_hazard),
        .branch_taken_EX (branch_taken_EX),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .en_IF           (en_IF),
        .en_ID           (en_ID),
        .en_EX           (en_EX),
        .en_MEM          (en_MEM),
        .en_WB           (en_WB),
        .flush_ID        (flush_ID),
        .flush_EX        (flush_EX),
        .state           (state),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {en_IF, en_ID, en_EX, en_MEM, en_WB, flush_ID, flush_EX, state};
    endfunction

    function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef PIPE_PERF_COUNTERS_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // in = {reset, load_use_hazard, branch_taken_EX, mem_req, mem_ready}
    task automatic drive(input logic [4:0] in, input logic [8:0] e);
        @(posedge clk);
        #1;
        {reset, load_use_hazard, branch_taken_EX, mem_req, mem_ready} = in;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        {reset, load_use_hazard, branch_taken_EX, mem_req, mem_ready} = 5'b10000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        @(posedge clk);
        #1;
        {reset, load_use_hazard, branch_taken_EX, mem_req, mem_ready} = 5'b11110;
        drive(5'b11110, {RST, 2'd0});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_outputs obs=%b exp=%b", obs(), e);
        end
        checks++;
        if (mem_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_status obs=%b/%0d/%0d exp=0/0/0",
                     mem_timeout, stall_cycles, flush_count);
        end
        drive(5'b00000, {ALL1, 2'd0});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_release obs=%b exp=%b", obs(), e);
        end
    endtask

    task automatic test_load_use();
        logic [4:0] st[3] = '{5'b01000, 5'b01000, 5'b00000};
        logic [8:0] ex[3] = '{{LDST, 2'd0}, {ALL1, 2'd1}, {ALL1, 2'd0}};
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL load_use cyc%0d obs=%b exp=%b", i, obs(), e);
            end
        end
        checks++;
        if (stall_cycles !== exp_cnt(1) || flush_count !== exp_cnt(0)) begin
            errors++;
            $display("FAIL load_use_counters obs=%0d/%0d exp=%0d/%0d",
                     stall_cycles, flush_count, exp_cnt(1), exp_cnt(0));
        end
    endtask

    task automatic test_branch();
        logic [4:0] st[3] = '{5'b00100, 5'b00100, 5'b00000};
        logic [8:0] ex[3] = '{{BRF, 2'd0}, {FLS, 2'd3}, {ALL1, 2'd0}};
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL branch cyc%0d obs=%b exp=%b", i, obs(), e);
            end
        end
        checks++;
        if (stall_cycles !== exp_cnt(0) || flush_count !== exp_cnt(1)) begin
            errors++;
            $display("FAIL branch_counters obs=%0d/%0d exp=%0d/%0d",
                     stall_cycles, flush_count, exp_cnt(0), exp_cnt(1));
        end
    endtask

    task automatic test_mem_wait();
        logic [4:0] st[6] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00011, 5'b00000};
        logic [8:0] ex[6] = '{{BLK, 2'd0}, {BLK, 2'd2}, {BLK, 2'd2}, {BLK, 2'd2},
                              {ALL1, 2'd2}, {ALL1, 2'd0}};
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mem_wait cyc%0d obs=%b exp=%b", i, obs(), e);
            end
        end
        checks++;
        if (stall_cycles !== exp_cnt(4) || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_status obs=%0d/%b exp=%0d/0",
                     stall_cycles, mem_timeout, exp_cnt(4));
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] st[4] = '{5'b01110, 5'b01111, 5'b00000, 5'b00000};
        logic [8:0] ex[4] = '{{BLK, 2'd0}, {BRF, 2'd2}, {FLS, 2'd3}, {ALL1, 2'd0}};
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL simultaneous cyc%0d obs=%b exp=%b", i, obs(), e);
            end
        end
        checks++;
        if (stall_cycles !== exp_cnt(1) || flush_count !== exp_cnt(1)) begin
            errors++;
            $display("FAIL simultaneous_counters obs=%0d/%0d exp=%0d/%0d",
                     stall_cycles, flush_count, exp_cnt(1), exp_cnt(1));
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] st[8] = '{5'b01000, 5'b01000, 5'b01000, 5'b00000,
                              5'b01100, 5'b01100, 5'b01000, 5'b00000};
        logic [8:0] ex[8] = '{{LDST, 2'd0}, {ALL1, 2'd1}, {LDST, 2'd0}, {ALL1, 2'd1},
                              {BRF, 2'd0}, {FLS, 2'd3}, {LDST, 2'd0}, {ALL1, 2'd1}};
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL back_to_back cyc%0d obs=%b exp=%b", i, obs(), e);
            end
        end
        checks++;
        if (stall_cycles !== exp_cnt(3) || flush_count !== exp_cnt(1)) begin
            errors++;
            $display("FAIL back_to_back_counters obs=%0d/%0d exp=%0d/%0d",
                     stall_cycles, flush_count, exp_cnt(3), exp_cnt(1));
        end
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        logic       exp_to;
        do_reset();
        drive(5'b00010, {BLK, 2'd0});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL timeout_enter obs=%b exp=%b", obs(), e);
        end
        // MEM_WAIT cycle k shows the timeout only after 8 full wait cycles.
        for (int k = 1; k <= 10; k++) begin
            drive(5'b00010, {BLK, 2'd2});
            e = sb.pop_front();
            exp_to = (k > 8);
            checks++;
            if (obs() !== e || mem_timeout !== exp_to) begin
                errors++;
                $display("FAIL timeout_wait k=%0d obs=%b/%b exp=%b/%b",
                         k, obs(), mem_timeout, e, exp_to);
            end
        end
        drive(5'b10010, {RST, 2'd2});
        e = sb.pop_front();
        checks++;
        if (obs() !== e || mem_timeout !== 1'b0 || stall_cycles !== 32'd0 ||
            flush_count !== 32'd0) begin
            errors++;
            $display("FAIL timeout_reset obs=%b/%b/%0d/%0d exp=%b/0/0/0",
                     obs(), mem_timeout, stall_cycles, flush_count, e);
        end
        drive(5'b00000, {ALL1, 2'd0});
        e = sb.pop_front();
        checks++;
        if (obs() !== e || mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL timeout_after_reset obs=%b/%b/%0d exp=%b/0/0",
                     obs(), mem_timeout, stall_cycles, e);
        end
        // Fresh wait after reset must start counting from zero again.
        drive(5'b00010, {BLK, 2'd0});
        e = sb.pop_front();
        for (int k = 1; k <= 3; k++) begin
            drive(5'b00010, {BLK, 2'd2});
            e = sb.pop_front();
        end
        checks++;
        if (obs() !== e || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rearm obs=%b/%b exp=%b/0", obs(), mem_timeout, e);
        end
    endtask

    initial begin
        reset           = 1'b1;
        load_use_hazard = 1'b0;
        branch_taken_EX = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain obs=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
